pong_score: RTL and testbench

Scoring and serve sequencer downstream of the ball mover. Consumes the ball's centre column each clock, detects a miss past either goal line, and increments the left and right scores. Gates ball motion through `ball_enable`, and issues a one-cycle `serve` pulse with a direction that re-launches the ball after a fixed hold. The game ends when either score reaches `WIN_SCORE`.

---
 rtl/pong_score.sv | 163 ++++++++++++++++
 tb/tb_pong_score.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pong_score.sv
//==============================================================================
// Module   : pong_score
// Purpose  : Pong scoring and serve sequencer. Detects misses past either
//            goal line, keeps both scores, gates ball motion and issues the
//            serve pulse after a fixed hold. Game ends at WIN_SCORE.
// Option   : PONG_SCORE_AUTO_RESTART_EN - GAME_OVER restarts by itself after
//            HOLD_CYCLES clocks (start still restarts immediately).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pong_score #(
   parameter int DISP_COLS   = 800,
   parameter int B_WIDTH     = 6,
   parameter int L_GOAL_COL  = 2,
   parameter int R_GOAL_COL  = DISP_COLS - 2,
   parameter int WIN_SCORE   = 7,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] ball_center_col,
   input  logic        start,
   output logic        ball_enable,
   output logic        serve,
   output logic        serve_dir,
   output logic [3:0]  l_score,
   output logic [3:0]  r_score,
   output logic [1:0]  winner,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      PLAY      = 2'b01,
      HOLD      = 2'b10,
      GAME_OVER = 2'b11
   } state_t;

   localparam int              CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERM  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [3:0]      WIN4  = 4'(WIN_SCORE);
   // 13-bit compare operands so col + half-width can never wrap
   localparam logic [12:0]     L_LIM = 13'(L_GOAL_COL + B_WIDTH / 2);
   localparam logic [12:0]     HALF  = 13'(B_WIDTH / 2);
   localparam logic [12:0]     R_LIM = 13'(R_GOAL_COL);

   state_t           cur, nxt;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             start_q;
   logic             be_n, serve_n, dir_n;
   logic [3:0]       l_n, r_n;
   logic [1:0]       win_n;

   logic [12:0] col13;
   logic        l_miss, r_miss, start_rise;

   assign col13      = {1'b0, ball_center_col};
   assign l_miss     = (col13 <= L_LIM);
   assign r_miss     = ((col13 + HALF) >= R_LIM);
   assign start_rise = start & ~start_q;
   assign state      = cur;

   // State and all registered outputs; reset is asynchronous
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur         <= IDLE;
         cnt         <= '0;
         start_q     <= 1'b0;
         ball_enable <= 1'b0;
         serve       <= 1'b0;
         serve_dir   <= 1'b1;
         l_score     <= 4'd0;
         r_score     <= 4'd0;
         winner      <= 2'b00;
      end else begin
         cur         <= nxt;
         cnt         <= cnt_n;
         start_q     <= start;
         ball_enable <= be_n;
         serve       <= serve_n;
         serve_dir   <= dir_n;
         l_score     <= l_n;
         r_score     <= r_n;
         winner      <= win_n;
      end
   end

   // Next-state and next-output decode; left miss has priority over right
   always_comb begin
      nxt     = cur;
      cnt_n   = cnt;
      serve_n = 1'b0;
      dir_n   = serve_dir;
      l_n     = l_score;
      r_n     = r_score;
      win_n   = winner;
      case (cur)
         IDLE: begin
            if (start_rise) begin
               nxt   = HOLD;
               dir_n = 1'b1;
               cnt_n = '0;
            end
         end
         PLAY: begin
            if (l_miss) begin
               r_n   = r_score + 4'd1;
               dir_n = 1'b0;
               if (r_n == WIN4) begin
                  nxt   = GAME_OVER;
                  win_n = 2'b10;
               end else begin
                  nxt = HOLD;
               end
            end else if (r_miss) begin
               l_n   = l_score + 4'd1;
               dir_n = 1'b1;
               if (l_n == WIN4) begin
                  nxt   = GAME_OVER;
                  win_n = 2'b01;
               end else begin
                  nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (cnt == TERM) begin
               nxt     = PLAY;
               serve_n = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         GAME_OVER: begin
`ifdef PONG_SCORE_AUTO_RESTART_EN
            if (start_rise || (cnt == TERM)) begin
`else
            if (start_rise) begin
`endif
               nxt   = HOLD;
               l_n   = 4'd0;
               r_n   = 4'd0;
               win_n = 2'b00;
               dir_n = 1'b1;
               cnt_n = '0;
            end else begin
`ifdef PONG_SCORE_AUTO_RESTART_EN
               cnt_n = cnt + CNT_W'(1);
`else
               cnt_n = cnt;
`endif
            end
         end
         default: nxt = IDLE;
      endcase
      be_n = (nxt == PLAY);
   end

endmodule

`default_nettype wire

// File: tb/tb_pong_score.sv
//==============================================================================
// Module   : tb_pong_score
// Purpose  : Directed self-checking bench for pong_score (HOLD_CYCLES = 4,
//            WIN_SCORE = 3) with a queue of expected output snapshots.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pong_score;

   localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01,
                          S_HOLD = 2'b10, S_GO   = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] ball_center_col;
   logic        start;
   logic        ball_enable, serve, serve_dir;
   logic [3:0]  l_score, r_score;
   logic [1:0]  winner, state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       be, sv, sd;
      logic [3:0] ls, rs;
      logic [1:0] win;
   } exp_t;
   exp_t sb[$];

   pong_score #(
      .DISP_COLS(800), .B_WIDTH(6), .L_GOAL_COL(2), .R_GOAL_COL(798),
      .WIN_SCORE(3), .HOLD_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .ball_center_col(ball_center_col), .start(start),
      .ball_enable(ball_enable), .serve(serve), .serve_dir(serve_dir),
      .l_score(l_score), .r_score(r_score), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [1:0] st, input logic be,
                       input logic sv, input logic sd, input logic [3:0] ls,
                       input logic [3:0] rs, input logic [1:0] win);
      exp_t e;
      e.tag = tag; e.st = st; e.be = be; e.sv = sv; e.sd = sd;
      e.ls = ls; e.rs = rs; e.win = win;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".state"},  {2'b00, state},  {2'b00, e.st});
         cmp({e.tag, ".ben"},    {3'b000, ball_enable}, {3'b000, e.be});
         cmp({e.tag, ".serve"},  {3'b000, serve},       {3'b000, e.sv});
         cmp({e.tag, ".dir"},    {3'b000, serve_dir},   {3'b000, e.sd});
         cmp({e.tag, ".lscore"}, l_score, e.ls);
         cmp({e.tag, ".rscore"}, r_score, e.rs);
         cmp({e.tag, ".winner"}, {2'b00, winner}, {2'b00, e.win});
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one clock, then compare outputs against the pushed expectation
   task automatic step(input string tag, input logic [1:0] st, input logic be,
                       input logic sv, input logic sd, input logic [3:0] ls,
                       input logic [3:0] rs, input logic [1:0] win);
      push(tag, st, be, sv, sd, ls, rs, win);
      cyc();
      pop_check();
   endtask

   // remaining three HOLD clocks after entry, then the serve clock
   task automatic hold_serve(input string tag, input logic sd,
                             input logic [3:0] ls, input logic [3:0] rs);
      for (int i = 0; i < 3; i++) step({tag, "_hold"}, S_HOLD, 0, 0, sd, ls, rs, 2'b00);
      step({tag, "_serve"}, S_PLAY, 1, 1, sd, ls, rs, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      ball_center_col = 12'd400;
      repeat (3) cyc();
      push("reset", S_IDLE, 0, 0, 1, 0, 0, 2'b00);
      pop_check();
      rst = 1'b0;
      step("idle", S_IDLE, 0, 0, 1, 0, 0, 2'b00);

      // first serve
      start = 1'b1;
      step("start", S_HOLD, 0, 0, 1, 0, 0, 2'b00);
      start = 1'b0;
      hold_serve("s1", 1, 0, 0);
      step("play1", S_PLAY, 1, 0, 1, 0, 0, 2'b00);

      // left boundary: 6 no miss, 5 miss
      ball_center_col = 12'd6;
      step("col6", S_PLAY, 1, 0, 1, 0, 0, 2'b00);
      ball_center_col = 12'd5;
      step("col5", S_HOLD, 0, 0, 0, 0, 1, 2'b00);
      ball_center_col = 12'd400;
      hold_serve("s2", 0, 0, 1);

      // right boundary: 794 no miss, 795 miss
      ball_center_col = 12'd794;
      step("col794", S_PLAY, 1, 0, 0, 0, 1, 2'b00);
      ball_center_col = 12'd795;
      step("col795", S_HOLD, 0, 0, 1, 1, 1, 2'b00);
      hold_serve("s3", 1, 1, 1);
      step("l2", S_HOLD, 0, 0, 1, 2, 1, 2'b00);
      ball_center_col = 12'd400;
      hold_serve("s4", 1, 2, 1);

      // start held high through PLAY is ignored and cannot retrigger later
      start = 1'b1;
      step("play_start", S_PLAY, 1, 0, 1, 2, 1, 2'b00);
      ball_center_col = 12'd795;
      step("win", S_GO, 0, 0, 1, 3, 1, 2'b01);
      ball_center_col = 12'd5;
      step("go_miss", S_GO, 0, 0, 1, 3, 1, 2'b01);
      step("go_held", S_GO, 0, 0, 1, 3, 1, 2'b01);
      start = 1'b0;
      step("go_low", S_GO, 0, 0, 1, 3, 1, 2'b01);
      start = 1'b1;
      ball_center_col = 12'd400;
      step("restart", S_HOLD, 0, 0, 1, 0, 0, 2'b00);
      start = 1'b0;

      // build 2/1 then reset asynchronously in the middle of HOLD
      hold_serve("s5", 1, 0, 0);
      ball_center_col = 12'd795;
      step("a1", S_HOLD, 0, 0, 1, 1, 0, 2'b00);
      hold_serve("s6", 1, 1, 0);
      step("a2", S_HOLD, 0, 0, 1, 2, 0, 2'b00);
      ball_center_col = 12'd400;
      hold_serve("s7", 1, 2, 0);
      ball_center_col = 12'd5;
      step("a3", S_HOLD, 0, 0, 0, 2, 1, 2'b00);
      ball_center_col = 12'd400;
      step("a3_hold", S_HOLD, 0, 0, 0, 2, 1, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      push("async_rst", S_IDLE, 0, 0, 1, 0, 0, 2'b00);
      pop_check();
      for (int i = 0; i < 6; i++) begin
         cyc();
         cmp("no_serve_in_rst", {3'b000, serve}, 4'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         cmp("no_serve_after_rst", {3'b000, serve}, 4'd0);
      end
      step("post_rst", S_IDLE, 0, 0, 1, 0, 0, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
